// File: rtl/lock_autopilot.sv
// lock_autopilot: walks one gondola through the canal lock by driving the lock command lines
module lock_autopilot #(
  parameter int W = 8,
  parameter int STEP_WAIT = 4,
  parameter int PORT_HOLD = 8,
  parameter int MAX_STEPS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dir,
  input  logic [W-1:0] outer_level,
  input  logic [W-1:0] lock_level,
  input  logic [W-1:0] inner_level,
  output logic         cmd_arrive,
  output logic         cmd_depart,
  output logic         cmd_outer,
  output logic         cmd_inner,
  output logic         cmd_raise,
  output logic         cmd_lower,
  output logic         busy,
  output logic         done,
  output logic         fault
);
  localparam int CW = $clog2((STEP_WAIT > PORT_HOLD ? STEP_WAIT : PORT_HOLD) + 1);
  localparam int SW = $clog2(MAX_STEPS + 1);
  typedef enum logic [3:0] {IDLE, ARRIVE, EQ1, OPEN1, CLOSE1, EQ2, OPEN2, CLOSE2, DONE, FAULT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] steps, steps_n;
  logic dir_q, dir_n, raise_n, lower_n, wait_done, hold_done;
  logic [W-1:0] target;
  // EQ1 targets the near side, EQ2 the far side
  assign target = ((state == EQ2) ^ dir_q) ? inner_level : outer_level;
  assign wait_done = cnt == CW'(STEP_WAIT - 1);
  assign hold_done = cnt == CW'(PORT_HOLD - 1);
  always_comb begin
    state_n = state;
    steps_n = steps;
    dir_n = dir_q;
    raise_n = 1'b0;
    lower_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = ARRIVE;
        dir_n = dir;
      end
      ARRIVE: begin
        state_n = EQ1;
        steps_n = '0;
      end
      EQ1, EQ2: if (wait_done) begin
        if (lock_level == target) state_n = (state == EQ1) ? OPEN1 : OPEN2;
        else if (steps == SW'(MAX_STEPS)) state_n = FAULT;
        else begin
          raise_n = lock_level < target;
          lower_n = lock_level > target;
          steps_n = steps + 1'b1;
        end
      end
      OPEN1: if (hold_done) state_n = CLOSE1;
      CLOSE1: begin
        state_n = EQ2;
        steps_n = '0;
      end
      OPEN2: if (hold_done) state_n = CLOSE2;
      CLOSE2: state_n = DONE;
      DONE: state_n = IDLE;
      FAULT: state_n = FAULT;
      default: state_n = IDLE;
    endcase
    // one counter times both the settle wait and the port hold; it restarts on every pulse or state change
    cnt_n = (state_n != state || raise_n || lower_n) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      steps <= '0;
      dir_q <= 1'b0;
      {cmd_arrive, cmd_depart, cmd_outer, cmd_inner, cmd_raise, cmd_lower, busy, done, fault} <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      steps <= steps_n;
      dir_q <= dir_n;
      cmd_arrive <= state_n inside {ARRIVE, EQ1, OPEN1};
      cmd_depart <= state_n == OPEN2;
      cmd_outer <= (state_n == OPEN1 && !dir_n) || (state_n == OPEN2 && dir_n);
      cmd_inner <= (state_n == OPEN1 && dir_n) || (state_n == OPEN2 && !dir_n);
      cmd_raise <= raise_n;
      cmd_lower <= lower_n;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      fault <= state_n == FAULT;
    end
  end
endmodule

// File: tb/tb_lock_autopilot.sv
// tb_lock_autopilot: randomized and directed transits checked against a pulse-count/duration model
module tb_lock_autopilot;
  localparam int W = 8, SW = 4, PH = 8, MS = 64;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, dir = 1'b0;
  logic [W-1:0] outer_level = '0, lock_level = '0, inner_level = '0;
  logic cmd_arrive, cmd_depart, cmd_outer, cmd_inner, cmd_raise, cmd_lower, busy, done, fault;
  int passed = 0, total = 0;
  bit frozen = 0;
  int cyc = 0, port_opens, dep_len, dep_bad, done_cnt, busy_len, arrive_len, spacing_bad, level_bad, last_pulse, last_ph;
  int n_up[2], n_dn[2], port_len[2];
  bit port_which[2];
  bit prev_port;
  int x_up[2], x_dn[2], x_busy, x_arrive;
  bit x_fault;

  always #5 clk = ~clk;

  lock_autopilot #(.W(W), .STEP_WAIT(SW), .PORT_HOLD(PH), .MAX_STEPS(MS)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir),
    .outer_level(outer_level), .lock_level(lock_level), .inner_level(inner_level),
    .cmd_arrive(cmd_arrive), .cmd_depart(cmd_depart), .cmd_outer(cmd_outer), .cmd_inner(cmd_inner),
    .cmd_raise(cmd_raise), .cmd_lower(cmd_lower), .busy(busy), .done(done), .fault(fault)
  );

  function automatic int clamp(input int v);
    return v < 0 ? 0 : (v > 255 ? 255 : v);
  endfunction

  task automatic reset_meas();
    port_opens = 0; dep_len = 0; dep_bad = 0; done_cnt = 0; busy_len = 0; arrive_len = 0;
    spacing_bad = 0; level_bad = 0; last_pulse = -100; last_ph = -1; prev_port = 0;
    for (int k = 0; k < 2; k++) begin
      n_up[k] = 0; n_dn[k] = 0; port_len[k] = 0; port_which[k] = 0;
    end
  endtask

  // one clock: sample outputs, check invariants, advance the water plant, log events
  task automatic tick();
    int ph;
    @(posedge clk); #1;
    cyc++;
    total++;
    if ((cmd_raise && cmd_lower) || (cmd_outer && cmd_inner) || ((cmd_raise || cmd_lower) && (cmd_outer || cmd_inner)))
      $display("FAIL invariant cycle %0d: raise=%b lower=%b outer=%b inner=%b, required mutually exclusive", cyc, cmd_raise, cmd_lower, cmd_outer, cmd_inner);
    else passed++;
    ph = port_opens > 0 ? 1 : 0;
    if (cmd_raise || cmd_lower) begin
      if (cmd_raise) n_up[ph]++; else n_dn[ph]++;
      if (last_ph == ph && cyc - last_pulse != SW) spacing_bad++;
      last_pulse = cyc; last_ph = ph;
      if (!frozen) lock_level = cmd_raise ? (lock_level == '1 ? lock_level : lock_level + 1'b1)
                                          : (lock_level == '0 ? lock_level : lock_level - 1'b1);
    end
    if ((cmd_outer || cmd_inner) && !prev_port) begin
      if (port_opens < 2) port_which[port_opens] = cmd_inner;
      if (lock_level != (cmd_inner ? inner_level : outer_level)) level_bad++;
      port_opens++;
    end
    if ((cmd_outer || cmd_inner) && port_opens >= 1 && port_opens <= 2) port_len[port_opens - 1]++;
    prev_port = cmd_outer || cmd_inner;
    if (cmd_depart) begin
      dep_len++;
      if (port_opens != 2 || !(cmd_outer || cmd_inner)) dep_bad++;
    end
    busy_len += int'(busy); arrive_len += int'(cmd_arrive); done_cnt += int'(done);
  endtask

  task automatic predict(input bit d, input int o, l, i);
    int near, far, n1, n2;
    near = d ? i : o; far = d ? o : i;
    n1 = near > l ? near - l : l - near;
    n2 = far > near ? far - near : near - far;
    x_fault = n1 > MS || n2 > MS;
    x_up[0] = near > l ? (n1 > MS ? MS : n1) : 0;
    x_dn[0] = near < l ? (n1 > MS ? MS : n1) : 0;
    x_up[1] = (n1 <= MS && far > near) ? (n2 > MS ? MS : n2) : 0;
    x_dn[1] = (n1 <= MS && far < near) ? (n2 > MS ? MS : n2) : 0;
    x_busy = SW * (n1 + n2 + 2) + 2 * PH + 4;
    x_arrive = 1 + SW * (n1 + 1) + PH;
  endtask

  task automatic test_reset();
    reset = 1; start = 1;
    tick(); tick();
    total++;
    if ({cmd_arrive, cmd_depart, cmd_outer, cmd_inner, cmd_raise, cmd_lower, busy, done, fault} !== 9'b0)
      $display("FAIL reset_outputs got %b required 000000000", {cmd_arrive, cmd_depart, cmd_outer, cmd_inner, cmd_raise, cmd_lower, busy, done, fault});
    else passed++;
    reset = 0; start = 0;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL reset_idle busy=%b required 0", busy); else passed++;
  endtask

  task automatic test_transit(input string name, input bit d, input int o, l, i);
    bit seen;
    predict(d, o, l, i);
    reset_meas();
    outer_level = W'(o); lock_level = W'(l); inner_level = W'(i); dir = d; start = 1;
    tick();
    start = 0; dir = ~d;
    seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      tick();
      seen = done || fault;
    end
    total++;
    if (!seen) $display("FAIL %s timeout: no done or fault in 2000 cycles, required one", name); else passed++;
    total++;
    if (fault !== x_fault) $display("FAIL %s fault=%b required %b", name, fault, x_fault); else passed++;
    total++;
    if (n_up[0] != x_up[0] || n_dn[0] != x_dn[0])
      $display("FAIL %s eq1_pulses up=%0d dn=%0d required up=%0d dn=%0d", name, n_up[0], n_dn[0], x_up[0], x_dn[0]);
    else passed++;
    total++;
    if (n_up[1] != x_up[1] || n_dn[1] != x_dn[1])
      $display("FAIL %s eq2_pulses up=%0d dn=%0d required up=%0d dn=%0d", name, n_up[1], n_dn[1], x_up[1], x_dn[1]);
    else passed++;
    total++;
    if (spacing_bad != 0 || level_bad != 0)
      $display("FAIL %s timing spacing_errs=%0d level_errs=%0d required 0 and 0", name, spacing_bad, level_bad);
    else passed++;
    if (x_fault) begin
      total++;
      if ({cmd_arrive, cmd_depart, cmd_outer, cmd_inner, cmd_raise, cmd_lower, busy} !== 7'b0000001)
        $display("FAIL %s fault_outputs got %b required 0000001", name, {cmd_arrive, cmd_depart, cmd_outer, cmd_inner, cmd_raise, cmd_lower, busy});
      else passed++;
    end else begin
      total++;
      if (port_opens != 2 || port_which[0] != d || port_which[1] != !d)
        $display("FAIL %s port_order opens=%0d first_inner=%b second_inner=%b required 2 %b %b", name, port_opens, port_which[0], port_which[1], d, !d);
      else passed++;
      total++;
      if (port_len[0] != PH || port_len[1] != PH)
        $display("FAIL %s port_len %0d,%0d required %0d,%0d", name, port_len[0], port_len[1], PH, PH);
      else passed++;
      total++;
      if (dep_len != PH || dep_bad != 0)
        $display("FAIL %s depart len=%0d misaligned=%0d required %0d and 0", name, dep_len, dep_bad, PH);
      else passed++;
      total++;
      if (done_cnt != 1 || busy_len != x_busy || arrive_len != x_arrive)
        $display("FAIL %s durations done=%0d busy=%0d arrive=%0d required 1 %0d %0d", name, done_cnt, busy_len, arrive_len, x_busy, x_arrive);
      else passed++;
      tick();
      total++;
      if ({busy, done} !== 2'b00) $display("FAIL %s after_done busy=%b done=%b required 0 0", name, busy, done); else passed++;
    end
    if (x_fault || !seen) begin
      reset = 1; tick(); reset = 0;
    end
  endtask

  task automatic test_fault();
    bit seen;
    int fault_cyc;
    reset_meas(); frozen = 1;
    outer_level = 50; lock_level = 10; inner_level = 10; dir = 0; start = 1;
    tick();
    start = 0; seen = 0; fault_cyc = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      tick();
      seen = fault;
      if (seen) fault_cyc = cyc;
    end
    total++;
    if (!seen || n_up[0] != MS || n_dn[0] != 0 || port_opens != 0)
      $display("FAIL frozen_pulses seen=%b up=%0d dn=%0d ports=%0d required 1 %0d 0 0", seen, n_up[0], n_dn[0], port_opens, MS);
    else passed++;
    total++;
    if (fault_cyc - last_pulse != SW) $display("FAIL frozen_fault_delay %0d required %0d", fault_cyc - last_pulse, SW); else passed++;
    total++;
    if ({cmd_arrive, cmd_depart, cmd_outer, cmd_inner, cmd_raise, cmd_lower, busy, done} !== 8'b00000010)
      $display("FAIL frozen_outputs got %b required 00000010", {cmd_arrive, cmd_depart, cmd_outer, cmd_inner, cmd_raise, cmd_lower, busy, done});
    else passed++;
    reset_meas(); start = 1;
    for (int k = 0; k < 10; k++) tick();
    start = 0;
    total++;
    if (arrive_len != 0 || busy_len != 10 || fault !== 1'b1 || n_up[0] != 0)
      $display("FAIL fault_sticky arrive=%0d busy=%0d fault=%b pulses=%0d required 0 10 1 0", arrive_len, busy_len, fault, n_up[0]);
    else passed++;
    reset = 1; tick(); reset = 0; frozen = 0;
    total++;
    if ({fault, busy} !== 2'b00) $display("FAIL fault_reset fault=%b busy=%b required 0 0", fault, busy); else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    reset_meas();
    outer_level = 20; lock_level = 20; inner_level = 30; dir = 0; start = 1;
    tick();
    start = 0; seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      seen = cmd_outer;
    end
    total++;
    if (!seen) $display("FAIL midreset_reach_open cmd_outer never 1, required 1"); else passed++;
    reset = 1;
    tick();
    total++;
    if ({cmd_arrive, cmd_depart, cmd_outer, cmd_inner, cmd_raise, cmd_lower, busy, done, fault} !== 9'b0)
      $display("FAIL midreset_outputs got %b required 000000000", {cmd_arrive, cmd_depart, cmd_outer, cmd_inner, cmd_raise, cmd_lower, busy, done, fault});
    else passed++;
    reset = 0;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL midreset_idle busy=%b required 0", busy); else passed++;
    test_transit("after_midreset", 0, 20, 17, 30);
  endtask

  task automatic test_back_to_back();
    bit seen;
    int exp;
    exp = 2 * SW + 2 * PH + 4;
    reset_meas();
    outer_level = 7; lock_level = 7; inner_level = 7; dir = 0; start = 1;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      seen = done;
    end
    total++;
    if (!seen || done_cnt != 1 || busy_len != exp)
      $display("FAIL held_start seen=%b done=%0d busy=%0d required 1 1 %0d", seen, done_cnt, busy_len, exp);
    else passed++;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL held_start_idle busy=%b required 0", busy); else passed++;
    tick();
    total++;
    if ({cmd_arrive, busy} !== 2'b11) $display("FAIL held_start_restart arrive=%b busy=%b required 1 1", cmd_arrive, busy); else passed++;
    reset_meas(); seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      start = 1'($urandom_range(0, 1));
      tick();
      seen = done;
    end
    start = 0;
    total++;
    if (!seen || done_cnt != 1 || busy_len != exp - 1)
      $display("FAIL midpulse_start seen=%b done=%0d busy=%0d required 1 1 %0d", seen, done_cnt, busy_len, exp - 1);
    else passed++;
    reset_meas();
    for (int k = 0; k < 3; k++) tick();
    total++;
    if (busy_len != 0) $display("FAIL midpulse_no_queue busy_cycles=%0d required 0", busy_len); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int near, l, f;
      bit d;
      d = 1'($urandom_range(0, 1));
      near = int'($urandom_range(0, 255));
      l = clamp(near + int'($urandom_range(0, 150)) - 75);
      f = clamp(near + int'($urandom_range(0, 150)) - 75);
      test_transit("random", d, d ? f : near, l, d ? near : f);
    end
  endtask

  initial begin
    test_reset();
    test_transit("dir0_raise", 0, 5, 2, 9);
    test_transit("dir1_lower", 1, 0, 4, 4);
    test_fault();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
